// File: rtl/trdb_reg.sv
// Tracer configuration register bank with a packet-word FIFO drained through the DUMP register.
// Each request is a two-state handshake: one IDLE cycle performing the access, one ACK cycle with per_ready_o.
module trdb_reg #(
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  per_valid_i,
    input  logic                  per_we_i,
    input  logic [ADDR_WIDTH-1:0] per_addr_i,
    input  logic [31:0]           per_wdata_i,
    output logic [31:0]           per_rdata_o,
    output logic                  per_ready_o,
    input  logic                  packet_valid_i,
    input  logic [31:0]           packet_data_i,
    output logic                  packet_ready_o,
    output logic                  trace_enable_o,
    output logic [31:0]           filter_lo_o,
    output logic [31:0]           filter_hi_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            enable_q, enable_d;
    logic            stall_en_q, stall_en_d;
    logic            overflow_q, overflow_d;
    logic [31:0]     filter_lo_q, filter_lo_d;
    logic [31:0]     filter_hi_q, filter_hi_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [31:0]     mem [FIFO_DEPTH];

    logic            access, wr_acc, rd_acc, in_window;
    logic            sel_ctrl, sel_status, sel_lo, sel_hi, sel_dump;
    logic            empty, full, pop, clear, push_req, push, ovf_evt;
    logic [31:0]     status_word, rd_val;
    logic [2:0]      reg_sel;
    logic            unused_addr_bits;

    // Bits above the 32-byte window must be zero so out-of-range addresses never alias a register.
    assign in_window        = (per_addr_i >> 5) == '0;
    assign reg_sel          = per_addr_i[4:2];
    assign unused_addr_bits = ^per_addr_i[1:0];

    assign access     = (state_q == IDLE) && per_valid_i;
    assign wr_acc     = access && per_we_i;
    assign rd_acc     = access && !per_we_i;
    assign sel_ctrl   = in_window && (reg_sel == 3'd0);
    assign sel_status = in_window && (reg_sel == 3'd1);
    assign sel_lo     = in_window && (reg_sel == 3'd2);
    assign sel_hi     = in_window && (reg_sel == 3'd3);
    assign sel_dump   = in_window && (reg_sel == 3'd4);

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign pop   = rd_acc && sel_dump && !empty;
    assign clear = wr_acc && sel_ctrl && per_wdata_i[1];

    // A pop in the same cycle frees a slot, so a held word may enter even when full.
    assign packet_ready_o = !enable_q || !stall_en_q || !full || pop;
    assign push_req       = packet_valid_i && packet_ready_o && enable_q;
    assign push           = push_req && (!full || pop) && !clear;
    assign ovf_evt        = push_req && full && !pop;

    assign status_word = {15'b0, 9'(level_q), 5'b0, overflow_q, full, empty};

    always_comb begin
        rd_val = 32'h0;
        if (sel_ctrl)   rd_val = {29'b0, stall_en_q, 1'b0, enable_q};
        if (sel_status) rd_val = status_word;
        if (sel_lo)     rd_val = filter_lo_q;
        if (sel_hi)     rd_val = filter_hi_q;
        if (sel_dump && !empty) rd_val = mem[rd_ptr_q];
    end

    always_comb begin
        state_d     = state_q;
        enable_d    = enable_q;
        stall_en_d  = stall_en_q;
        filter_lo_d = filter_lo_q;
        filter_hi_d = filter_hi_q;
        rdata_d     = 32'h0;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE: begin
                if (per_valid_i) begin
                    state_d = ACK;
                    if (per_we_i) begin
                        if (sel_ctrl) begin
                            enable_d   = per_wdata_i[0];
                            stall_en_d = per_wdata_i[2];
                        end
                        if (sel_lo) filter_lo_d = per_wdata_i;
                        if (sel_hi) filter_hi_d = per_wdata_i;
                        if (sel_status && per_wdata_i[2]) overflow_d = 1'b0;
                    end else begin
                        rdata_d = rd_val;
                    end
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A new overflow event outranks a simultaneous write-1-to-clear.
        if (ovf_evt) overflow_d = 1'b1;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            level_d = level_q + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            enable_q    <= 1'b0;
            stall_en_q  <= 1'b0;
            overflow_q  <= 1'b0;
            filter_lo_q <= 32'h0;
            filter_hi_q <= 32'h0;
            rdata_q     <= 32'h0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            stall_en_q  <= stall_en_d;
            overflow_q  <= overflow_d;
            filter_lo_q <= filter_lo_d;
            filter_hi_q <= filter_hi_d;
            rdata_q     <= rdata_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= packet_data_i;
    end

    assign per_ready_o    = (state_q == ACK);
    assign per_rdata_o    = rdata_q;
    assign trace_enable_o = enable_q;
    assign filter_lo_o    = filter_lo_q;
    assign filter_hi_o    = filter_hi_q;

endmodule

// File: tb/tb_trdb_reg.sv
// Self-checking bench for trdb_reg: register map, packet FIFO, overflow/stall, clear and reset.
module tb_trdb_reg;
    localparam int AW    = 12;
    localparam int DEPTH = 16;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          per_valid_i = 1'b0;
    logic          per_we_i = 1'b0;
    logic [AW-1:0] per_addr_i = '0;
    logic [31:0]   per_wdata_i = '0;
    logic [31:0]   per_rdata_o;
    logic          per_ready_o;
    logic          packet_valid_i = 1'b0;
    logic [31:0]   packet_data_i = '0;
    logic          packet_ready_o;
    logic          trace_enable_o;
    logic [31:0]   filter_lo_o;
    logic [31:0]   filter_hi_o;

    trdb_reg #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .per_valid_i(per_valid_i), .per_we_i(per_we_i), .per_addr_i(per_addr_i),
        .per_wdata_i(per_wdata_i), .per_rdata_o(per_rdata_o), .per_ready_o(per_ready_o),
        .packet_valid_i(packet_valid_i), .packet_data_i(packet_data_i),
        .packet_ready_o(packet_ready_o), .trace_enable_o(trace_enable_o),
        .filter_lo_o(filter_lo_o), .filter_hi_o(filter_hi_o)
    );

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: software-visible state and the FIFO contents as a queue.
    logic [31:0] mq[$];
    bit          m_en, m_stall, m_ovf;
    logic [31:0] m_lo, m_hi;

    logic        ack_en, ready_after;
    logic [31:0] ack_lo, ack_hi;

    function automatic logic [31:0] mdl_status();
        int n = mq.size();
        return (32'(n) << 8) | (m_ovf ? 32'h4 : 32'h0) |
               ((n == DEPTH) ? 32'h2 : 32'h0) | ((n == 0) ? 32'h1 : 32'h0);
    endfunction

    function automatic logic [31:0] mdl_ctrl();
        return (m_stall ? 32'h4 : 32'h0) | (m_en ? 32'h1 : 32'h0);
    endfunction

    function automatic bit mdl_ready();
        return !m_en || !m_stall || (mq.size() < DEPTH);
    endfunction

    function automatic void mdl_push(input logic [31:0] w);
        if (!m_en) return;
        if (mq.size() < DEPTH) mq.push_back(w);
        else if (!m_stall) m_ovf = 1'b1;
    endfunction

    // Called 1 time unit after a rising edge. lat counts the cycles of the access,
    // the cycle valid is first driven in being cycle 1.
    task automatic bus(input bit we, input logic [AW-1:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat);
        int cyc = 1;
        per_valid_i = 1'b1; per_we_i = we; per_addr_i = addr; per_wdata_i = wd;
        lat = 0; rd = 32'h0;
        while (lat == 0 && cyc < 10) begin
            @(posedge clk_i); #1; cyc++;
            if (per_ready_o) begin
                lat = cyc; rd = per_rdata_o;
                ack_en = trace_enable_o; ack_lo = filter_lo_o; ack_hi = filter_hi_o;
            end
        end
        if (lat == 0) begin
            n_assert++; n_fail++;
            $display("FAIL bus_timeout addr=0x%03h: per_ready_o never rose, required within 2 cycles", addr);
        end
        $display("%s addr=0x%03h wdata=0x%08h rdata=0x%08h latency=%0d", we ? "WR" : "RD", addr, wd, rd, lat);
        @(posedge clk_i); #1;
        ready_after = per_ready_o;
        per_valid_i = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, output logic rdy);
        packet_valid_i = 1'b1; packet_data_i = w;
        @(negedge clk_i); rdy = packet_ready_o;
        @(posedge clk_i); #1;
        packet_valid_i = 1'b0;
        $display("PUSH data=0x%08h ready=%0b", w, rdy);
    endtask

    task automatic test_reset();
        logic [31:0] rd, exp_v [5];
        int lat;
        repeat (3) @(posedge clk_i);
        n_assert++;
        if ({per_ready_o, packet_ready_o, trace_enable_o} !== 3'b010 || per_rdata_o !== 0 ||
            filter_lo_o !== 0 || filter_hi_o !== 0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%0b pkt_ready=%0b en=%0b rdata=%h lo=%h hi=%h required 0,1,0,0,0,0",
                     per_ready_o, packet_ready_o, trace_enable_o, per_rdata_o, filter_lo_o, filter_hi_o);
        end
        #1 rst_i = 1'b0;
        m_en = 0; m_stall = 0; m_ovf = 0; m_lo = 0; m_hi = 0; mq.delete();
        exp_v = '{32'h0, 32'h1, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 5; i++) begin
            bus(1'b0, AW'(i * 4), 32'h0, rd, lat);
            n_assert++;
            if (rd !== exp_v[i] || lat != 2 || ready_after !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_read_%0d: rdata=%h lat=%0d ready_after=%0b required %h, 2, 0",
                         i, rd, lat, ready_after, exp_v[i]);
            end
        end
    endtask

    task automatic test_config();
        logic [31:0] rd, lo, hi;
        int lat;
        bus(1'b1, 12'h008, 32'h1C000000, rd, lat); m_lo = 32'h1C000000;
        bus(1'b1, 12'h00C, 32'h1C00FFFF, rd, lat); m_hi = 32'h1C00FFFF;
        n_assert++;
        if (ack_hi !== m_hi || ack_lo !== m_lo) begin
            n_fail++; $display("FAIL filter_ack: lo=%h hi=%h required %h %h", ack_lo, ack_hi, m_lo, m_hi);
        end
        bus(1'b1, 12'h000, 32'h1, rd, lat); m_en = 1;
        n_assert++;
        if (ack_en !== 1'b1) begin n_fail++; $display("FAIL enable_ack: en=%0b required 1", ack_en); end
        bus(1'b1, 12'h020, 32'hFFFFFFFF, rd, lat);
        bus(1'b0, 12'h020, 32'h0, rd, lat);
        n_assert++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h required 0", rd); end
        bus(1'b0, 12'h000, 32'h0, rd, lat);
        n_assert++;
        if (rd !== mdl_ctrl() || trace_enable_o !== m_en) begin
            n_fail++; $display("FAIL ctrl_readback: got %h en=%0b required %h", rd, trace_enable_o, mdl_ctrl());
        end
        for (int i = 0; i < 4; i++) begin
            lo = $urandom; hi = $urandom;
            bus(1'b1, 12'h008, lo, rd, lat); m_lo = lo;
            bus(1'b1, 12'h00C, hi, rd, lat); m_hi = hi;
            n_assert++;
            if (ack_hi !== m_hi || filter_lo_o !== m_lo) begin
                n_fail++; $display("FAIL rand_filter_out_%0d: lo=%h hi=%h required %h %h", i, filter_lo_o, ack_hi, m_lo, m_hi);
            end
            bus(1'b0, 12'h008, 32'h0, rd, lat);
            n_assert++;
            if (rd !== m_lo) begin n_fail++; $display("FAIL rand_lo_read_%0d: got %h required %h", i, rd, m_lo); end
            bus(1'b0, 12'h00C, 32'h0, rd, lat);
            n_assert++;
            if (rd !== m_hi) begin n_fail++; $display("FAIL rand_hi_read_%0d: got %h required %h", i, rd, m_hi); end
        end
    endtask

    task automatic test_disabled();
        logic [31:0] rd;
        logic rdy;
        int lat;
        bus(1'b1, 12'h000, 32'h0, rd, lat); m_en = 0;
        push_word($urandom, rdy);
        bus(1'b0, 12'h004, 32'h0, rd, lat);
        n_assert++;
        if (rdy !== 1'b1 || rd !== mdl_status()) begin
            n_fail++; $display("FAIL disabled_push: ready=%0b status=%h required 1 %h", rdy, rd, mdl_status());
        end
        bus(1'b1, 12'h000, 32'h1, rd, lat); m_en = 1;
    endtask

    task automatic test_fifo_basic();
        logic [31:0] rd, w [3];
        logic rdy;
        int lat;
        w = '{32'hA, 32'hB, 32'hC};
        for (int i = 0; i < 3; i++) begin push_word(w[i], rdy); mdl_push(w[i]); end
        bus(1'b0, 12'h004, 32'h0, rd, lat);
        n_assert++;
        if (rd !== mdl_status()) begin n_fail++; $display("FAIL level3_status: got %h required %h", rd, mdl_status()); end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            e = (mq.size() > 0) ? mq.pop_front() : 32'h0;
            bus(1'b0, 12'h010, 32'h0, rd, lat);
            n_assert++;
            if (rd !== e) begin n_fail++; $display("FAIL dump_%0d: got %h required %h", i, rd, e); end
        end
        bus(1'b0, 12'h004, 32'h0, rd, lat);
        n_assert++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL drained_status: got %h required 00000001", rd); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd, w;
        logic rdy;
        int lat, bad = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            w = $urandom; push_word(w, rdy); mdl_push(w);
            if (rdy !== mdl_ready()) bad++;
        end
        n_assert++;
        if (bad != 0) begin n_fail++; $display("FAIL ovf_ready: %0d pushes saw ready=0, required 0 such pushes", bad); end
        bus(1'b0, 12'h004, 32'h0, rd, lat);
        n_assert++;
        if (rd !== 32'h1006 || rd !== mdl_status()) begin
            n_fail++; $display("FAIL ovf_status: got %h required %h", rd, mdl_status());
        end
        bus(1'b1, 12'h004, 32'h4, rd, lat); m_ovf = 0;
        bus(1'b0, 12'h004, 32'h0, rd, lat);
        n_assert++;
        if (rd !== mdl_status()) begin n_fail++; $display("FAIL ovf_w1c: got %h required %h", rd, mdl_status()); end
    endtask

    task automatic test_stall();
        logic [31:0] rd, w, e;
        logic rdy;
        int lat;
        bus(1'b1, 12'h000, 32'h5, rd, lat); m_stall = 1;
        push_word($urandom, rdy);
        n_assert++;
        if (rdy !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %0b required 0", rdy); end
        w = $urandom;
        packet_valid_i = 1'b1; packet_data_i = w;
        e = mq.pop_front(); mq.push_back(w);
        bus(1'b0, 12'h010, 32'h0, rd, lat);
        packet_valid_i = 1'b0;
        n_assert++;
        if (rd !== e) begin n_fail++; $display("FAIL stall_pop: got %h required %h", rd, e); end
        bus(1'b0, 12'h004, 32'h0, rd, lat);
        n_assert++;
        if (rd !== mdl_status()) begin n_fail++; $display("FAIL stall_level: got %h required %h", rd, mdl_status()); end
        while (mq.size() > 0) begin
            e = mq.pop_front();
            bus(1'b0, 12'h010, 32'h0, rd, lat);
            n_assert++;
            if (rd !== e) begin n_fail++; $display("FAIL drain_order: got %h required %h", rd, e); end
        end
    endtask

    task automatic test_clear_and_reset();
        logic [31:0] rd;
        int lat;
        bus(1'b1, 12'h000, 32'h1, rd, lat); m_stall = 0;
        packet_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            packet_data_i = $urandom; mdl_push(packet_data_i);
            @(posedge clk_i); #1;
        end
        packet_valid_i = 1'b0;
        bus(1'b0, 12'h004, 32'h0, rd, lat);
        n_assert++;
        if (rd !== mdl_status()) begin n_fail++; $display("FAIL preclear_status: got %h required %h", rd, mdl_status()); end
        packet_valid_i = 1'b1; packet_data_i = $urandom;
        per_valid_i = 1'b1; per_we_i = 1'b1; per_addr_i = 12'h000; per_wdata_i = 32'h3;
        @(posedge clk_i); #1;
        packet_valid_i = 1'b0;
        mq.delete(); m_en = 1;
        n_assert++;
        if (per_ready_o !== 1'b1 || trace_enable_o !== 1'b1) begin
            n_fail++; $display("FAIL clear_ack: ready=%0b en=%0b required 1 1", per_ready_o, trace_enable_o);
        end
        $display("WR addr=0x000 wdata=0x00000003 (clear with push pending)");
        @(posedge clk_i); #1; per_valid_i = 1'b0;
        bus(1'b0, 12'h004, 32'h0, rd, lat);
        n_assert++;
        if (rd !== mdl_status()) begin n_fail++; $display("FAIL clear_status: got %h required %h", rd, mdl_status()); end
        bus(1'b0, 12'h000, 32'h0, rd, lat);
        n_assert++;
        if (rd !== mdl_ctrl()) begin n_fail++; $display("FAIL clear_ctrl: got %h required %h", rd, mdl_ctrl()); end
        per_valid_i = 1'b1; per_we_i = 1'b0; per_addr_i = 12'h008;
        @(posedge clk_i); #1;
        n_assert++;
        if (per_ready_o !== 1'b1 || per_rdata_o !== m_lo) begin
            n_fail++; $display("FAIL prereset_ack: ready=%0b rdata=%h required 1 %h", per_ready_o, per_rdata_o, m_lo);
        end
        rst_i = 1'b1; #1;
        n_assert++;
        if ({per_ready_o, packet_ready_o, trace_enable_o} !== 3'b010 || per_rdata_o !== 0 ||
            filter_lo_o !== 0 || filter_hi_o !== 0) begin
            n_fail++;
            $display("FAIL midreset_outputs: ready=%0b pkt_ready=%0b en=%0b rdata=%h lo=%h hi=%h required 0,1,0,0,0,0",
                     per_ready_o, packet_ready_o, trace_enable_o, per_rdata_o, filter_lo_o, filter_hi_o);
        end
        $display("RESET asserted during ACK");
        per_valid_i = 1'b0;
        @(posedge clk_i); #1; rst_i = 1'b0;
        m_en = 0; m_stall = 0; m_ovf = 0; m_lo = 0; m_hi = 0; mq.delete();
        bus(1'b0, 12'h004, 32'h0, rd, lat);
        n_assert++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL postreset_status: got %h required 00000001", rd); end
    endtask

    initial begin
        test_reset();
        test_config();
        test_disabled();
        test_fifo_basic();
        test_overflow();
        test_stall();
        test_clear_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
